// File: rtl/i2s_tdm_transceiver.sv
`default_nettype none
// ============================================================================
// Module     : i2s_tdm_transceiver
// Description: Full-duplex I2S / left-justified / TDM serial audio port with
//              one-frame tx and rx holding buffers.
// Revision   : 1.0 - initial release
// ============================================================================
module i2s_tdm_transceiver #(
    parameter int DW      = 24,
    parameter int SLOT_W  = 32,
    parameter int CH      = 2,
    parameter int MCK_DIV = 8,
    parameter int MODE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             sck,
    output logic             ws,
    output logic             sdout,
    input  logic             sdin,
    input  logic [CH*DW-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [CH*DW-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_start,
    output logic             tx_underrun,
    output logic             rx_overrun
);

    localparam int c_N     = CH * SLOT_W;
    localparam int c_CW    = $clog2(MCK_DIV);
    localparam int c_PW    = $clog2(c_N);
    localparam int c_D     = (MODE == 0) ? 1 : 0;
    localparam int c_RW    = (CH - 1) * SLOT_W + DW;
    localparam int c_P_RX  = ((CH - 1) * SLOT_W + c_D + DW - 1) % c_N;

    localparam logic [c_CW-1:0] c_C_FALL = c_CW'(MCK_DIV - 1);
    localparam logic [c_CW-1:0] c_C_RISE = c_CW'(MCK_DIV / 2 - 1);
    localparam logic [c_CW-1:0] c_C_HALF = c_CW'(MCK_DIV / 2);
    localparam logic [c_PW-1:0] c_P_LAST = c_PW'(c_N - 1);
    localparam logic [c_PW-1:0] c_P_RXL  = c_PW'(c_P_RX);
    localparam logic [c_PW-1:0] c_P_SLOT = c_PW'(SLOT_W);

    logic [c_CW-1:0]  r_c;
    logic [c_PW-1:0]  r_p;
    logic             r_sck;
    logic             r_ws;
    logic             r_sdout;
    logic [c_N-1:0]   r_tx_sr;
    logic [CH*DW-1:0] r_tx_buf;
    logic             r_tx_full;
    logic [c_RW-2:0]  r_rx_sr;
    logic [CH*DW-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_overrun;

    logic [c_CW-1:0]  w_c_nxt;
    logic [c_PW-1:0]  w_p_nxt;
    logic             w_fall;
    logic             w_rise;
    logic             w_load;
    logic             w_ws_nxt;
    logic             w_rx_done;
    logic [CH*DW-1:0] w_tx_src;
    logic [c_N-1:0]   w_tx_frame;
    logic [c_RW-1:0]  w_rx_shift;
    logic [CH*DW-1:0] w_rx_frame;

    assign w_fall     = (r_c == c_C_FALL);
    assign w_rise     = (r_c == c_C_RISE);
    assign w_c_nxt    = w_fall ? '0 : r_c + 1'b1;
    assign w_load     = w_fall && (r_p == c_P_LAST);
    assign w_p_nxt    = w_fall ? ((r_p == c_P_LAST) ? '0 : r_p + 1'b1) : r_p;
    assign w_ws_nxt   = (CH == 2) ? (w_p_nxt >= c_P_SLOT) : (w_p_nxt == '0);
    assign w_rx_done  = w_rise && (r_p == c_P_RXL);
    assign w_tx_src   = r_tx_full ? r_tx_buf : '0;
    assign w_rx_shift = {r_rx_sr, sdin};

    // Frame vector is laid out MSB-first in slot order, each sample left-aligned in its slot
    for (genvar k = 0; k < CH; k++) begin : g_slot
        if (DW < SLOT_W) begin : g_pad
            assign w_tx_frame[c_N-1-k*SLOT_W -: SLOT_W] =
                {w_tx_src[k*DW +: DW], {(SLOT_W-DW){1'b0}}};
        end else begin : g_full
            assign w_tx_frame[c_N-1-k*SLOT_W -: SLOT_W] = w_tx_src[k*DW +: DW];
        end
        assign w_rx_frame[k*DW +: DW] = w_rx_shift[(CH-1-k)*SLOT_W +: DW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c     <= '0;
            r_p     <= '0;
            r_sck   <= 1'b0;
            r_ws    <= 1'b0;
            r_sdout <= 1'b0;
            r_tx_sr <= '0;
        end else begin
            r_c   <= w_c_nxt;
            r_sck <= (w_c_nxt >= c_C_HALF);
            if (w_fall) begin
                r_p  <= w_p_nxt;
                r_ws <= w_ws_nxt;
                if (w_load && MODE == 0) begin
                    // Last bit of the outgoing frame spills into p=0 of the new one
                    r_sdout <= r_tx_sr[c_N-1];
                    r_tx_sr <= w_tx_frame;
                end else if (w_load) begin
                    r_sdout <= w_tx_frame[c_N-1];
                    r_tx_sr <= {w_tx_frame[c_N-2:0], 1'b0};
                end else begin
                    r_sdout <= r_tx_sr[c_N-1];
                    r_tx_sr <= {r_tx_sr[c_N-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_full <= 1'b0;
            r_tx_buf  <= '0;
        end else begin
            if (w_load && r_tx_full) begin
                r_tx_full <= 1'b0;
            end
            if (tx_valid && !r_tx_full) begin
                r_tx_full <= 1'b1;
                r_tx_buf  <= tx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sr      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (w_rise) begin
                r_rx_sr <= w_rx_shift[c_RW-2:0];
            end
            if (w_rx_done) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= w_rx_frame;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign sck         = r_sck;
    assign ws          = r_ws;
    assign sdout       = r_sdout;
    assign tx_ready    = !r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_start = w_load;
    assign tx_underrun = w_load && !r_tx_full;
    assign rx_overrun  = r_rx_overrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_transceiver.sv
`default_nettype none
// ============================================================================
// Module     : tb_i2s_tdm_transceiver
// Description: Directed self-checking bench for i2s_tdm_transceiver.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_transceiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    int   t0  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default I2S, loopback
    logic        sck_a, ws_a, sdout_a, tx_ready_a, rx_valid_a, fs_a, und_a, ovr_a;
    logic        tx_valid_a = 1'b0;
    logic        rx_ready_a = 1'b1;
    logic [47:0] tx_data_a  = '0;
    logic [47:0] rx_data_a;

    i2s_tdm_transceiver #(.DW(24), .SLOT_W(32), .CH(2), .MCK_DIV(8), .MODE(0)) u_dut (
        .clk(clk), .rst(rst), .sck(sck_a), .ws(ws_a), .sdout(sdout_a), .sdin(sdout_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .frame_start(fs_a), .tx_underrun(und_a), .rx_overrun(ovr_a)
    );

    // Instance B: left-justified
    logic        sck_b, ws_b, sdout_b, tx_ready_b, rx_valid_b, fs_b, und_b, ovr_b;
    logic        tx_valid_b = 1'b0;
    logic        rx_ready_b = 1'b1;
    logic [47:0] tx_data_b  = '0;
    logic [47:0] rx_data_b;

    i2s_tdm_transceiver #(.DW(24), .SLOT_W(32), .CH(2), .MCK_DIV(8), .MODE(1)) u_lj (
        .clk(clk), .rst(rst), .sck(sck_b), .ws(ws_b), .sdout(sdout_b), .sdin(sdout_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .frame_start(fs_b), .tx_underrun(und_b), .rx_overrun(ovr_b)
    );

    // Instance C: 4-slot TDM, 16-bit slots, loopback
    logic        sck_c, ws_c, sdout_c, tx_ready_c, rx_valid_c, fs_c, und_c, ovr_c;
    logic        tx_valid_c = 1'b0;
    logic        rx_ready_c = 1'b1;
    logic [63:0] tx_data_c  = '0;
    logic [63:0] rx_data_c;

    i2s_tdm_transceiver #(.DW(16), .SLOT_W(16), .CH(4), .MCK_DIV(8), .MODE(0)) u_tdm (
        .clk(clk), .rst(rst), .sck(sck_c), .ws(ws_c), .sdout(sdout_c), .sdin(sdout_c),
        .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
        .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c),
        .frame_start(fs_c), .tx_underrun(und_c), .rx_overrun(ovr_c)
    );

    // n = number of clk edges since reset release, observed on the falling edge
    task automatic do_reset();
        rst = 1'b1;
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        tx_valid_c = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
    endtask

    task automatic wait_n(input int target);
        while (cyc - t0 < target) @(negedge clk);
    endtask

    task automatic send_a(input logic [47:0] d);
        int k = 0;
        while (!tx_ready_a && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!tx_ready_a) begin
            n_fail++;
            $display("FAIL send_a_timeout: tx_ready=%b required 1", tx_ready_a);
        end
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        n_checks++;
        if (tx_ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL send_a_ready_drop: tx_ready=%b required 0", tx_ready_a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sck_a, ws_a, sdout_a, tx_ready_a, rx_valid_a, fs_a, und_a, ovr_a} !== 8'b0001_0000) begin
            n_fail++;
            $display("FAIL reset_a_ctl: got %b required 00010000",
                     {sck_a, ws_a, sdout_a, tx_ready_a, rx_valid_a, fs_a, und_a, ovr_a});
        end
        n_checks++;
        if (rx_data_a !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_a_rx_data: got %h required 0", rx_data_a);
        end
        n_checks++;
        if ({sck_c, ws_c, sdout_c, tx_ready_c, rx_valid_c, rx_data_c} !== {5'b00010, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_c: ctl %b data %h required 00010 / 0",
                     {sck_c, ws_c, sdout_c, tx_ready_c, rx_valid_c}, rx_data_c);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_timing();
        logic e_sck, e_ws, e_und;
        do_reset();
        rx_ready_a = 1'b1;
        for (int n = 1; n <= 1100; n++) begin
            wait_n(n);
            e_sck = ((n % 8) >= 4);
            e_ws  = ((n % 512) >= 256);
            e_und = ((n % 512) == 511);
            n_checks++;
            if ({sck_a, ws_a, sdout_a, und_a, fs_a} !== {e_sck, e_ws, 1'b0, e_und, e_und}) begin
                n_fail++;
                $display("FAIL idle_timing n=%0d: sck/ws/sdout/und/fs got %b required %b",
                         n, {sck_a, ws_a, sdout_a, und_a, fs_a}, {e_sck, e_ws, 1'b0, e_und, e_und});
                break;
            end
        end
    endtask

    task automatic test_loopback_i2s();
        int got_n;
        do_reset();
        rx_ready_a = 1'b1;
        wait_n(1);
        send_a(48'hA5A5A5_123456);
        wait_n(511);
        n_checks++;
        if ({fs_a, und_a, tx_ready_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL loop_frame_start: fs/und/ready got %b required 100", {fs_a, und_a, tx_ready_a});
        end
        wait_n(512);
        n_checks++;
        if (tx_ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_ready_after_load: got %b required 1", tx_ready_a);
        end
        got_n = -1;
        for (int k = 0; k < 700; k++) begin
            if (rx_valid_a === 1'b1) begin
                got_n = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (got_n != 964) begin
            n_fail++;
            $display("FAIL loop_rx_latency: rx_valid at n=%0d required 964", got_n);
        end
        n_checks++;
        if (rx_data_a !== 48'hA5A5A5_123456) begin
            n_fail++;
            $display("FAIL loop_rx_data: got %h required a5a5a5123456", rx_data_a);
        end
        @(negedge clk);
        n_checks++;
        if (rx_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_rx_valid_clear: got %b required 0", rx_valid_a);
        end
    endtask

    task automatic test_left_justified();
        do_reset();
        wait_n(1);
        tx_data_b  = {24'h000000, 24'h800000};
        tx_valid_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
        wait_n(511);
        n_checks++;
        if (sdout_b !== 1'b0) begin
            n_fail++;
            $display("FAIL lj_pre_frame: sdout got %b required 0", sdout_b);
        end
        wait_n(512);
        n_checks++;
        if ({sdout_b, ws_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL lj_msb_p0: sdout/ws got %b required 10", {sdout_b, ws_b});
        end
        wait_n(519);
        n_checks++;
        if (sdout_b !== 1'b1) begin
            n_fail++;
            $display("FAIL lj_msb_hold: sdout got %b required 1", sdout_b);
        end
        for (int p = 1; p < 32; p++) begin
            wait_n(512 + 8 * p + 4);
            n_checks++;
            if (sdout_b !== 1'b0) begin
                n_fail++;
                $display("FAIL lj_tail p=%0d: sdout got %b required 0", p, sdout_b);
                break;
            end
        end
    endtask

    task automatic test_tdm_loopback();
        int pts [5]  = '{511, 512, 519, 520, 1024};
        logic e_ws [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        rx_ready_c = 1'b1;
        wait_n(1);
        tx_data_c  = {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
        tx_valid_c = 1'b1;
        @(negedge clk);
        tx_valid_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_n(pts[i]);
            n_checks++;
            if (ws_c !== e_ws[i]) begin
                n_fail++;
                $display("FAIL tdm_ws n=%0d: got %b required %b", pts[i], ws_c, e_ws[i]);
            end
            if (pts[i] == 512) begin
                wait_n(516);
                n_checks++;
                if ({rx_valid_c, rx_data_c} !== {1'b1, 64'h0}) begin
                    n_fail++;
                    $display("FAIL tdm_rx_empty_frame: valid %b data %h required 1 / 0", rx_valid_c, rx_data_c);
                end
            end
        end
        wait_n(1028);
        n_checks++;
        if (rx_valid_c !== 1'b1) begin
            n_fail++;
            $display("FAIL tdm_rx_valid: got %b required 1", rx_valid_c);
        end
        n_checks++;
        if (rx_data_c !== 64'hFFFF_8000_7FFF_0001) begin
            n_fail++;
            $display("FAIL tdm_rx_data: got %h required ffff80007fff0001", rx_data_c);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        rx_ready_a = 1'b1;
        wait_n(1);
        send_a(48'h00ABCD_FEDCBA);
        wait_n(460);
        rx_ready_a = 1'b0;
        wait_n(513);
        send_a(48'h111111_222222);
        wait_n(1025);
        send_a(48'h333333_444444);
        wait_n(964);
        n_checks++;
        if ({rx_valid_a, rx_data_a} !== {1'b1, 48'h00ABCD_FEDCBA}) begin
            n_fail++;
            $display("FAIL ovr_first_frame: valid %b data %h required 1 / 00abcdfedcba", rx_valid_a, rx_data_a);
        end
        wait_n(1475);
        n_checks++;
        if (ovr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_early: got %b required 0", ovr_a);
        end
        wait_n(1476);
        n_checks++;
        if (ovr_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_pulse1: got %b required 1", ovr_a);
        end
        wait_n(1477);
        n_checks++;
        if (ovr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_pulse1_width: got %b required 0", ovr_a);
        end
        wait_n(1988);
        n_checks++;
        if (ovr_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_pulse2: got %b required 1", ovr_a);
        end
        wait_n(1990);
        n_checks++;
        if ({rx_valid_a, rx_data_a} !== {1'b1, 48'h00ABCD_FEDCBA}) begin
            n_fail++;
            $display("FAIL ovr_held: valid %b data %h required 1 / 00abcdfedcba", rx_valid_a, rx_data_a);
        end
        rx_ready_a = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rx_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_release: rx_valid got %b required 0", rx_valid_a);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        rx_ready_a = 1'b0;
        wait_n(1);
        send_a({24'hFFFFFF, 24'h000000});
        wait_n(513);
        send_a(48'h5A5A5A_5A5A5A);
        wait_n(832);
        n_checks++;
        if ({ws_a, sdout_a, tx_ready_a, rx_valid_a} !== 4'b1101) begin
            n_fail++;
            $display("FAIL mid_precondition: ws/sdout/ready/valid got %b required 1101",
                     {ws_a, sdout_a, tx_ready_a, rx_valid_a});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        n_checks++;
        if ({sck_a, ws_a, sdout_a, tx_ready_a, rx_valid_a} !== 5'b00010) begin
            n_fail++;
            $display("FAIL mid_reset_state: sck/ws/sdout/ready/valid got %b required 00010",
                     {sck_a, ws_a, sdout_a, tx_ready_a, rx_valid_a});
        end
        n_checks++;
        if (rx_data_a !== 48'h0) begin
            n_fail++;
            $display("FAIL mid_reset_rx_data: got %h required 0", rx_data_a);
        end
        wait_n(255);
        n_checks++;
        if (ws_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ws_255: got %b required 0", ws_a);
        end
        wait_n(256);
        n_checks++;
        if (ws_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ws_256: got %b required 1", ws_a);
        end
        wait_n(511);
        n_checks++;
        if ({fs_a, und_a} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_restart_underrun: fs/und got %b required 11", {fs_a, und_a});
        end
    endtask

    initial begin
        test_reset();
        test_idle_timing();
        test_loopback_i2s();
        test_left_justified();
        test_tdm_loopback();
        test_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
